mandelbrot_seq: RTL and testbench



---
 rtl/mandelbrot_seq.sv | 162 ++++++++++++++++
 tb/tb_mandelbrot_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_seq.sv
// Per-pixel Mandelbrot sequencer: accepts one point, iterates z <= z^2 + c through
// a single combinational iterator (one step per clock), and returns count/escaped/tag.

module mandelbrot_iter #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH:0] in_re,
  input  logic signed [WIDTH:0] in_im,
  input  logic signed [WIDTH:0] p_re,
  input  logic signed [WIDTH:0] p_im,
  output logic signed [WIDTH:0] out_re,
  output logic signed [WIDTH:0] out_im,
  output logic                  conv_out
);
  localparam int FRAC = WIDTH - 7;
  localparam int PW   = 2 * (WIDTH + 1);
  localparam logic signed [PW-1:0] LIM = PW'(4) <<< FRAC;

  logic signed [PW-1:0] re_x, im_x, pre_x, pim_x;
  logic signed [PW-1:0] pr_rr, pr_ii, pr_ri;
  logic signed [PW-1:0] sq_rr, sq_ii, sq_ri;
  logic signed [PW-1:0] mag, sum_re, sum_im;

  assign re_x  = PW'(in_re);
  assign im_x  = PW'(in_im);
  assign pre_x = PW'(p_re);
  assign pim_x = PW'(p_im);

  assign pr_rr = re_x * re_x;
  assign pr_ii = im_x * im_x;
  assign pr_ri = re_x * im_x;

  // Rescale products back to Q8.25; the cross term carries the factor of two
  // by shifting one bit less.
  assign sq_rr = pr_rr >>> FRAC;
  assign sq_ii = pr_ii >>> FRAC;
  assign sq_ri = pr_ri >>> (FRAC - 1);

  assign mag      = sq_rr + sq_ii;
  assign conv_out = (mag <= LIM);

  assign sum_re = sq_rr - sq_ii + pre_x;
  assign sum_im = sq_ri + pim_x;
  assign out_re = sum_re[WIDTH:0];
  assign out_im = sum_im[WIDTH:0];
endmodule

module mandelbrot_seq #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16,
  parameter int TAG_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [WIDTH:0] in_p_re,
  input  logic signed [WIDTH:0] in_p_im,
  input  logic [ITER_W-1:0]     in_max_iter,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_W-1:0]     out_count,
  output logic                  out_escaped,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH:0] z_re, z_im, p_re, p_im;
  logic signed [WIDTH:0] nz_re, nz_im;
  logic                  conv;
  logic [ITER_W-1:0]     cnt, max_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  accept, esc_hit, lim_hit, step, xfer;

  mandelbrot_iter #(.WIDTH(WIDTH)) u_iter (
    .in_re    (z_re),
    .in_im    (z_im),
    .p_re     (p_re),
    .p_im     (p_im),
    .out_re   (nz_re),
    .out_im   (nz_im),
    .conv_out (conv)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    esc_hit   = 1'b0;
    lim_hit   = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept    = 1'b1;
        state_nxt = ITER;
      end
      // Escape wins over the limit, so a point escaping on its last allowed step
      // still reports escaped.
      ITER: if (!conv) begin
        esc_hit   = 1'b1;
        state_nxt = DONE;
      end else if (cnt == max_q) begin
        lim_hit   = 1'b1;
        state_nxt = DONE;
      end else begin
        step = 1'b1;
      end
      DONE: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_re        <= '0;
      z_im        <= '0;
      p_re        <= '0;
      p_im        <= '0;
      cnt         <= '0;
      max_q       <= '0;
      tag_q       <= '0;
      out_count   <= '0;
      out_escaped <= 1'b0;
      out_tag     <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (accept) begin
        p_re  <= in_p_re;
        p_im  <= in_p_im;
        max_q <= in_max_iter;
        tag_q <= in_tag;
        z_re  <= '0;
        z_im  <= '0;
        cnt   <= '0;
      end
      if (step) begin
        z_re <= nz_re;
        z_im <= nz_im;
        cnt  <= cnt + 1'b1;
      end
      if (esc_hit || lim_hit) begin
        out_count   <= esc_hit ? cnt : max_q;
        out_escaped <= esc_hit;
        out_tag     <= tag_q;
      end
      // Registered off DONE, so the result is presented one cycle after entry.
      out_valid <= (state == DONE) && !xfer;
    end
  end
endmodule

// File: tb/tb_mandelbrot_seq.sv
// Self-checking bench for mandelbrot_seq against a plain-integer escape-time model.

module tb_mandelbrot_seq;
  localparam int WIDTH  = 32;
  localparam int ITER_W = 16;
  localparam int TAG_W  = 20;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid, in_ready;
  logic signed [WIDTH:0] in_p_re, in_p_im;
  logic [ITER_W-1:0]     in_max_iter;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid, out_ready;
  logic [ITER_W-1:0]     out_count;
  logic                  out_escaped;
  logic [TAG_W-1:0]      out_tag;
  logic                  busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mandelbrot_seq #(.WIDTH(WIDTH), .ITER_W(ITER_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p_re(in_p_re), .in_p_im(in_p_im),
    .in_max_iter(in_max_iter), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_escaped(out_escaped),
    .out_tag(out_tag), .busy(busy)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Escape-time reference: z_{k+1} = z_k^2 + c in Q8.25, strict |z|^2 > 4 test
  // made before each step, limit taken when k reaches max.
  task automatic model(input longint cr, input longint ci, input int mx,
                       output int n, output bit esc);
    longint zr, zi, rr, ii, ri;
    zr = 0; zi = 0;
    n = 0; esc = 1'b0;
    forever begin
      rr = (zr * zr) >>> 25;
      ii = (zi * zi) >>> 25;
      if (rr + ii > 64'sd134217728) begin esc = 1'b1; return; end
      if (n == mx) return;
      ri = (zr * zi) >>> 24;
      zr = rr - ii + cr;
      zi = ri + ci;
      n++;
    end
  endtask

  task automatic send(input longint cr, input longint ci, input int mx, input int tg);
    chk("accept_ready", longint'(in_ready), 1);
    in_p_re     = 33'(cr);
    in_p_im     = 33'(ci);
    in_max_iter = 16'(mx);
    in_tag      = 20'(tg);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Call #1 after the accept edge; expects out_valid exactly n+2 edges after it.
  task automatic wait_res(input int n, input bit esc, input int tg);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_valid && k < n + 10);
    chk("latency", k, n + 2);
    chk("count", longint'(out_count), n);
    chk("escaped", longint'(out_escaped), longint'(esc));
    chk("tag", longint'(out_tag), tg);
    chk("busy_done", longint'(busy), 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", longint'(out_valid), 0);
    chk("drain_ready", longint'(in_ready), 1);
  endtask

  task automatic run_point(input longint cr, input longint ci, input int mx, input int tg);
    int n;
    bit esc;
    model(cr, ci, mx, n, esc);
    send(cr, ci, mx, tg);
    wait_res(n, esc, tg);
    drain();
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_p_re = '0; in_p_im = '0; in_max_iter = '0; in_tag = '0;
    #3;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_count", longint'(out_count), 0);
    chk("rst_tag", longint'(out_tag), 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed points with hand-known answers.
    send(67108864, 0, 100, 20'h00a01);
    wait_res(2, 1'b1, 20'h00a01);
    drain();
    send(33554432, 0, 100, 20'h00a02);
    wait_res(3, 1'b1, 20'h00a02);
    drain();
    send(0, 0, 50, 20'h00a03);
    wait_res(50, 1'b0, 20'h00a03);
    drain();
    send(0, 0, 0, 20'h00a04);
    wait_res(0, 1'b0, 20'h00a04);
    drain();
    run_point(-45214105, 2097152, 255, 20'h00a05);

    // Backpressure: result must hold and the pending request must stay out.
    send(67108864, 0, 100, 20'h0b0b0);
    wait_res(2, 1'b1, 20'h0b0b0);
    in_p_re = 33'(33554432); in_p_im = '0; in_max_iter = 16'd100;
    in_tag = 20'h0c0c0; in_valid = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || out_count != 16'd2 || out_tag != 20'h0b0b0 || in_ready) seen++;
    end
    chk("bp_stable_cycles", seen, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_xfer_valid", longint'(out_valid), 0);
    chk("bp_xfer_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_busy", longint'(busy), 1);
    wait_res(3, 1'b1, 20'h0c0c0);
    drain();

    // Randomized points inside |c| < 2.
    for (int i = 0; i < 24; i++) begin
      longint cr, ci;
      cr = longint'($urandom_range(94000000)) - 47000000;
      ci = longint'($urandom_range(94000000)) - 47000000;
      run_point(cr, ci, int'($urandom_range(80)), int'($urandom_range(20'hfffff)));
    end

    // Asynchronous reset in the middle of an iteration: no result may follow.
    send(0, 0, 50, 20'h0dead);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", longint'(in_ready), 1);
    chk("arst_out_valid", longint'(out_valid), 0);
    chk("arst_busy", longint'(busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("arst_no_result", seen, 0);
    run_point(67108864, 0, 100, 20'h00e01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
